// File: rtl/pc_mux_pkg.sv
// rtl/pc_mux_pkg.sv - next-PC select encoding driven by decode/execute
package pc_mux_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } sel_pc_t;

endpackage

// File: rtl/type_pkg.sv
// rtl/type_pkg.sv - shared data/address types and the NOP encoding
package type_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  localparam data_t NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of {addr, data} with flush
module fetch_buffer
  import type_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [31:0]                  push_addr,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output logic [31:0]                  head_addr,
  output logic [31:0]                  head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  addr_t         mem_addr [DEPTH];
  data_t         mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          full;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flush wins over both push and pop: a redirect kills whatever arrives with it.
  assign do_push   = push && !flush;
  assign do_pop    = pop && !flush && !empty;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Pointers and fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Callers size their traffic so an unpopped push never lands on a full buffer.
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(do_push && full && !do_pop));

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch front end with redirect and stale-response drop
module inst_fetch
  import type_pkg::*;
  import pc_mux_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        ir_valid,
  input  logic        id_ready,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] imm,
  input  logic        br_taken,
  input  logic [31:0] rs1_data,
  input  logic        flash
);

  localparam int          CW  = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] CAP = (CW+1)'(BUF_DEPTH);

  addr_t         fetch_pc;
  addr_t         target;
  addr_t         req_pc;
  addr_t         buf_pc;
  data_t         buf_ir;
  data_t         pcq_data_unused;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] pcq_count;
  logic          buf_empty;
  logic          pcq_empty;
  logic          issued;
  logic          retire;
  logic          redirect;
  logic          drop_resp;
  logic          accept_resp;
  logic          pcq_unused;
  sel_pc_t       sel;

  // The fetch window counts stale requests too, so drops can never overrun it.
  assign imem_req        = !rst && (({1'b0, outstanding} + {1'b0, buf_count}) < CAP);
  assign imem_addr       = fetch_pc;
  assign issued          = imem_req && imem_gnt;
  assign retire          = ir_valid && id_ready;
  assign drop_resp       = imem_rvalid && (drop_cnt != '0);
  assign accept_resp     = imem_rvalid && (drop_cnt == '0);
  assign outstanding_nxt = outstanding + CW'(issued) - CW'(imem_rvalid);

  assign ir_valid = !buf_empty;
  assign ir       = buf_empty ? NOP : buf_ir;
  assign pc       = buf_empty ? RESET_PC : buf_pc;

  assign pcq_unused = ^{pcq_count, pcq_empty, pcq_data_unused};

  // Redirect decision and target; flash overrides whatever pc_sel says.
  always_comb begin
    sel      = sel_pc_t'(pc_sel);
    redirect = 1'b0;
    target   = pc + 32'd4;
    if (flash) begin
      redirect = 1'b1;
    end else begin
      case (sel)
        PC_JAL: begin
          redirect = 1'b1;
          target   = pc + imm;
        end
        PC_BRANCH: begin
          redirect = br_taken;
          target   = pc + imm;
        end
        PC_JALR: begin
          redirect = 1'b1;
          target   = (rs1_data + imm) & ~32'h1;
        end
        default: redirect = 1'b0;
      endcase
    end
    redirect = redirect && retire;
  end

  // Fetch PC, in-flight count and the number of stale responses still to discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= target;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (issued)    fetch_pc <= fetch_pc + 32'd4;
        if (drop_resp) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // PCs of live requests in issue order; responses are tagged from its head.
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (issued),
    .push_addr (fetch_pc),
    .push_data (NOP),
    .pop       (accept_resp),
    .head_addr (req_pc),
    .head_data (pcq_data_unused),
    .count     (pcq_count),
    .empty     (pcq_empty)
  );

  // Returned words waiting for decode/execute.
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (accept_resp),
    .push_addr (req_pc),
    .push_data (imem_rdata),
    .pop       (retire),
    .head_addr (buf_pc),
    .head_data (buf_ir),
    .count     (buf_count),
    .empty     (buf_empty)
  );

endmodule
